// File: rtl/mc_pkg.sv
// Shared constants, state codes and control-word type for the multicycle MIPS control FSM.
// Optional build macro MC_BNE_EN adds BNE (opcode 000101) to the legal opcode set.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMMOP_NONE = 2'b00;
  localparam logic [1:0] IMMOP_ADD  = 2'b01;
  localparam logic [1:0] IMMOP_AND  = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       branch_inv;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic [1:0] immop;
    logic       illegal;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI: opcode_legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                                                 opcode_legal = 1'b1;
`endif
      default:                                                opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of the FSM state (plus opcode where needed) into the datapath control word.
// Honors MC_BNE_EN: when defined, BRANCH inverts the zero test for BNE.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.irwrite  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.pcwrite  = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.illegal = ~opcode_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_RT;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.pcwritecond = 1'b1;
`ifdef MC_BNE_EN
        ctrl.branch_inv  = (opcode == OP_BNE);
`endif
      end
      S_JUMP: begin
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.pcwrite  = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
        if (opcode == OP_ADDI)      ctrl.immop = IMMOP_ADD;
        else if (opcode == OP_ANDI) ctrl.immop = IMMOP_AND;
        else                        ctrl.immop = IMMOP_NONE;
      end
      S_IMMWB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state logic, pc_en, reset gating.
// Build macro MC_BNE_EN makes opcode 000101 (BNE) legal and routes it to BRANCH.
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] immedateop,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_RTYPE;
          OP_BEQ:           state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:           state_d = S_BRANCH;
`endif
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ANDI: state_d = S_IMMEX;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_RTYPE:  state_d = S_RWB;
      S_IMMEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: state is sequential, so it is updated with <= only; the async reset puts it in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  // Reset holds every output low, including FETCH's strobes, the moment rst_n falls.
  assign ctrl_g = rst_n ? ctrl : '0;

  assign pc_en      = ctrl_g.pcwrite | (ctrl_g.pcwritecond & (zero ^ ctrl_g.branch_inv));
  assign iord       = ctrl_g.iord;
  assign memread    = ctrl_g.memread;
  assign memwrite   = ctrl_g.memwrite;
  assign irwrite    = ctrl_g.irwrite;
  assign memtoreg   = ctrl_g.memtoreg;
  assign regdst     = ctrl_g.regdst;
  assign regwrite   = ctrl_g.regwrite;
  assign alusrca    = ctrl_g.alusrca;
  assign alusrcb    = ctrl_g.alusrcb;
  assign pcsource   = ctrl_g.pcsource;
  assign aluop1     = ctrl_g.aluop[1];
  assign aluop0     = ctrl_g.aluop[0];
  assign immedateop = ctrl_g.immop;
  assign illegal    = ctrl_g.illegal;
  assign state      = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state and control-vector checks.
// Build with MC_BNE_EN defined to exercise the taken-BNE path instead of the illegal pulse.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsource, immedateop;
  logic       aluop1, aluop0, illegal;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .pc_en      (pc_en),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsource   (pcsource),
    .aluop1     (aluop1),
    .aluop0     (aluop0),
    .immedateop (immedateop),
    .illegal    (illegal),
    .state      (state)
  );

  // {pc_en,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,pcsource,aluop1,aluop0,immop,illegal}
  logic [17:0] ctl;
  assign ctl = {pc_en, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca,
                alusrcb, pcsource, aluop1, aluop0, immedateop, illegal};

  localparam logic [17:0] C_ZERO   = 18'b0_0_0_0_0_0_0_0_0_00_00_0_0_00_0;
  localparam logic [17:0] C_FETCH  = 18'b1_0_1_0_1_0_0_0_0_01_00_0_0_00_0;
  localparam logic [17:0] C_DECODE = 18'b0_0_0_0_0_0_0_0_0_11_00_0_0_00_0;
  localparam logic [17:0] C_DECILL = 18'b0_0_0_0_0_0_0_0_0_11_00_0_0_00_1;
  localparam logic [17:0] C_MEMADR = 18'b0_0_0_0_0_0_0_0_1_10_00_0_0_00_0;
  localparam logic [17:0] C_MEMRD  = 18'b0_1_1_0_0_0_0_0_0_00_00_0_0_00_0;
  localparam logic [17:0] C_MEMWB  = 18'b0_0_0_0_0_1_0_1_0_00_00_0_0_00_0;
  localparam logic [17:0] C_MEMWR  = 18'b0_1_0_1_0_0_0_0_0_00_00_0_0_00_0;
  localparam logic [17:0] C_RTYPE  = 18'b0_0_0_0_0_0_0_0_1_00_00_1_0_00_0;
  localparam logic [17:0] C_RWB    = 18'b0_0_0_0_0_0_1_1_0_00_00_0_0_00_0;
  localparam logic [17:0] C_BR_T   = 18'b1_0_0_0_0_0_0_0_1_00_01_0_1_00_0;
  localparam logic [17:0] C_BR_NT  = 18'b0_0_0_0_0_0_0_0_1_00_01_0_1_00_0;
  localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_00_10_0_0_00_0;
  localparam logic [17:0] C_ADDI   = 18'b0_0_0_0_0_0_0_0_1_10_00_0_0_01_0;
  localparam logic [17:0] C_ANDI   = 18'b0_0_0_0_0_0_0_0_1_10_00_0_0_10_0;
  localparam logic [17:0] C_IMMWB  = 18'b0_0_0_0_0_0_0_1_0_00_00_0_0_00_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already set: settle, check state and controls, advance one cycle.
  task automatic cyc(input string tag, input int exp_state, input logic [17:0] exp_ctl);
    #1;
    check({tag, ".state"}, {28'd0, state}, exp_state);
    check({tag, ".ctl"},   {14'd0, ctl},   {14'd0, exp_ctl});
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.state", {28'd0, state}, 32'd0);
    check("reset.ctl",   {14'd0, ctl},   {14'd0, C_ZERO});
    @(negedge clk);
    rst_n = 1'b1;

    // LW: 5 cycles
    opcode = 6'b100011;
    cyc("lw.fetch", 0, C_FETCH);
    cyc("lw.decode", 1, C_DECODE);
    cyc("lw.memadr", 2, C_MEMADR);
    cyc("lw.memrd", 3, C_MEMRD);
    cyc("lw.memwb", 4, C_MEMWB);

    // R-type: 4 cycles
    opcode = 6'b000000;
    cyc("r.fetch", 0, C_FETCH);
    cyc("r.decode", 1, C_DECODE);
    cyc("r.rtype", 6, C_RTYPE);
    cyc("r.rwb", 7, C_RWB);

    // BEQ taken
    opcode = 6'b000100;
    zero   = 1'b1;
    cyc("beq_t.fetch", 0, C_FETCH);
    cyc("beq_t.decode", 1, C_DECODE);
    cyc("beq_t.branch", 8, C_BR_T);

    // BEQ not taken
    zero = 1'b0;
    cyc("beq_n.fetch", 0, C_FETCH);
    cyc("beq_n.decode", 1, C_DECODE);
    cyc("beq_n.branch", 8, C_BR_NT);

    // J
    opcode = 6'b000010;
    cyc("j.fetch", 0, C_FETCH);
    cyc("j.decode", 1, C_DECODE);
    cyc("j.jump", 9, C_JUMP);

    // ADDI, ANDI
    opcode = 6'b001000;
    cyc("addi.fetch", 0, C_FETCH);
    cyc("addi.decode", 1, C_DECODE);
    cyc("addi.immex", 10, C_ADDI);
    cyc("addi.immwb", 11, C_IMMWB);
    opcode = 6'b001100;
    cyc("andi.fetch", 0, C_FETCH);
    cyc("andi.decode", 1, C_DECODE);
    cyc("andi.immex", 10, C_ANDI);
    cyc("andi.immwb", 11, C_IMMWB);

    // Illegal opcode: 2 cycles
    opcode = 6'b111111;
    cyc("ill.fetch", 0, C_FETCH);
    cyc("ill.decode", 1, C_DECILL);

    // BNE: taken on zero=0 when enabled, illegal otherwise
    opcode = 6'b000101;
    zero   = 1'b0;
    cyc("bne.fetch", 0, C_FETCH);
`ifdef MC_BNE_EN
    cyc("bne.decode", 1, C_DECODE);
    cyc("bne.branch_t", 8, C_BR_T);
    zero = 1'b1;
    cyc("bne.fetch2", 0, C_FETCH);
    cyc("bne.decode2", 1, C_DECODE);
    cyc("bne.branch_n", 8, C_BR_NT);
`else
    cyc("bne.decode", 1, C_DECILL);
`endif

    // SW with reset pulsed in MEMWR
    opcode = 6'b101011;
    zero   = 1'b0;
    cyc("sw.fetch", 0, C_FETCH);
    cyc("sw.decode", 1, C_DECODE);
    cyc("sw.memadr", 2, C_MEMADR);
    #1;
    check("sw.memwr.state", {28'd0, state}, 32'd5);
    check("sw.memwr.ctl",   {14'd0, ctl},   {14'd0, C_MEMWR});
    rst_n = 1'b0;
    #1;
    check("rst_mid.memwrite", {31'd0, memwrite}, 32'd0);
    check("rst_mid.state",    {28'd0, state},    32'd0);
    check("rst_mid.ctl",      {14'd0, ctl},      {14'd0, C_ZERO});
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst.fetch", 0, C_FETCH);
    cyc("post_rst.decode", 1, C_DECODE);
    cyc("post_rst.memadr", 2, C_MEMADR);
    cyc("post_rst.memwr", 5, C_MEMWR);
    cyc("post_rst.back", 0, C_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
